// File: rtl/uart_pkg.sv
// Shared types and default timing constants for the UART transmit arbiter.
package uart_pkg;

   localparam int DEF_CLK_DIV    = 10416;
   localparam int DEF_FRAME_BITS = 10;
   localparam int DEF_GAP_CYCLES = 2;
   localparam int FIFO_DEPTH     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous first-word-fall-through FIFO; accepts a push while full when a pop happens in the same cycle.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   // DEPTH must be a power of two so the pointers wrap by plain overflow.
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter between a host byte stream and echoed receive bytes, pacing one UART frame at a time.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_vld,
   input  logic [7:0] req0_data,
   output logic       req0_rdy,
   input  logic       rx_vld,
   input  logic [7:0] rx_data,
   input  logic       echo_en,
   output logic       tx_vld,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       fifo_ovf
);

   localparam int FRAME_CYCLES = CLK_DIV * FRAME_BITS + GAP_CYCLES;
   localparam int TW           = $clog2(FRAME_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYCLES - 1);

   arb_state_t    state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          last_grant, last_grant_nxt;
   logic [7:0]    tx_data_nxt;
   logic          grant0, grant1;

   logic          fifo_push;
   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;

   assign fifo_push = rx_vld && echo_en;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_echo_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (rx_data),
      .pop       (grant1),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Host handshake: a byte transfers on any cycle where req0_vld and req0_rdy are both high;
   // req0_rdy is only offered in IDLE when the host wins arbitration, and never during reset.
   assign req0_rdy = rst && grant0;
   assign tx_vld   = (state == LOAD);
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt      = state;
      timer_nxt      = timer;
      last_grant_nxt = last_grant;
      tx_data_nxt    = tx_data;
      grant0         = 1'b0;
      grant1         = 1'b0;
      case (state)
         IDLE: begin
            // last_grant=1 means the echo FIFO was served last, so the host wins a tie.
            grant1 = !fifo_empty && (!req0_vld || !last_grant);
            grant0 = req0_vld && !grant1;
            if (grant0) begin
               tx_data_nxt    = req0_data;
               last_grant_nxt = 1'b0;
               state_nxt      = LOAD;
            end else if (grant1) begin
               tx_data_nxt    = fifo_dout;
               last_grant_nxt = 1'b1;
               state_nxt      = LOAD;
            end
         end
         LOAD: begin
            timer_nxt = TIMER_LOAD;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (timer == '0) begin
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         timer      <= '0;
         last_grant <= 1'b1;
         tx_data    <= 8'h00;
         fifo_ovf   <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         last_grant <= last_grant_nxt;
         tx_data    <= tx_data_nxt;
         if (fifo_push && fifo_full && !grant1) begin
            fifo_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short frame (FRAME_CYCLES = 42, pulse spacing 44).
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0_vld = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req0_rdy;
   logic       rx_vld = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       echo_en = 1'b0;
   logic       tx_vld;
   logic [7:0] tx_data;
   logic       busy;
   logic       fifo_ovf;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .CLK_DIV    (4),
      .FRAME_BITS (10),
      .GAP_CYCLES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0_vld  (req0_vld),
      .req0_data (req0_data),
      .req0_rdy  (req0_rdy),
      .rx_vld    (rx_vld),
      .rx_data   (rx_data),
      .echo_en   (echo_en),
      .tx_vld    (tx_vld),
      .tx_data   (tx_data),
      .busy      (busy),
      .fifo_ovf  (fifo_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Steps until the next tx_vld pulse; checks cycle distance and byte against the expected queue.
   task automatic wait_tx(input int exp_gap, input string tag);
      int n = 0;
      logic [31:0] e;
      do begin
         @(negedge clk);
         rx_vld = 1'b0;
         #1;
         n++;
      end while (!tx_vld && n < 200);
      chk({tag, "_gap"}, n, exp_gap);
      if (exp_q.size() != 0) e = 32'(exp_q.pop_front());
      else e = 32'hffff_ffff;
      chk({tag, "_data"}, 32'(tx_data), e);
   endtask

   task automatic no_tx(input int cycles, input string tag);
      int pulses = 0;
      repeat (cycles) begin
         @(negedge clk);
         rx_vld = 1'b0;
         #1;
         if (tx_vld) pulses++;
      end
      chk(tag, pulses, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req0_vld = 1'b0;
      rx_vld = 1'b0;
      echo_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic rx_push(input logic [7:0] d, input logic en);
      @(negedge clk);
      rx_vld = 1'b1;
      rx_data = d;
      echo_en = en;
   endtask

   task automatic quiet(input int k);
      repeat (k) begin
         @(negedge clk);
         rx_vld = 1'b0;
      end
   endtask

   initial begin
      int n;

      // Reset state, with the host already offering a byte
      rst = 1'b0;
      req0_vld = 1'b1;
      req0_data = 8'h41;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_rdy", req0_rdy, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tx_vld", tx_vld, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_ovf", fifo_ovf, 1'b0);

      // Single host byte
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("host_rdy", req0_rdy, 1'b1);
      chk("host_busy_idle", busy, 1'b0);
      exp_q.push_back(8'h41);
      wait_tx(1, "host");
      req0_vld = 1'b0;
      chk("host_busy_load", busy, 1'b1);
      n = 1;
      do begin
         @(negedge clk);
         #1;
         if (busy) n++;
      end while (busy && n < 200);
      chk("host_busy_len", n, 43);
      chk("host_rdy_off", req0_rdy, 1'b0);

      // Tie after reset: host first, then FIFO, then host again
      do_reset();
      rx_push(8'hA0, 1'b1);
      @(negedge clk);
      rx_vld = 1'b0;
      req0_vld = 1'b1;
      req0_data = 8'h55;
      #1;
      chk("tie_rdy", req0_rdy, 1'b1);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'h56);
      wait_tx(1, "tie0");
      req0_data = 8'h56;
      wait_tx(44, "tie1");
      wait_tx(44, "tie2");
      req0_vld = 1'b0;
      no_tx(60, "tie_extra");

      // Echo gating
      rx_push(8'h31, 1'b0);
      rx_push(8'h32, 1'b1);
      exp_q.push_back(8'h32);
      wait_tx(2, "echo");
      no_tx(60, "echo_extra");

      // Overflow: six pushes during HOLD, only four kept
      do_reset();
      @(negedge clk);
      req0_vld = 1'b1;
      req0_data = 8'h77;
      exp_q.push_back(8'h77);
      wait_tx(1, "ovf_host");
      req0_vld = 1'b0;
      rx_push(8'h01, 1'b1);
      rx_push(8'h02, 1'b1);
      rx_push(8'h03, 1'b1);
      rx_push(8'h04, 1'b1);
      rx_push(8'h05, 1'b1);
      #1;
      chk("ovf_not_yet", fifo_ovf, 1'b0);
      rx_push(8'h06, 1'b1);
      #1;
      chk("ovf_set", fifo_ovf, 1'b1);
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      wait_tx(38, "ovf_b1");
      wait_tx(44, "ovf_b2");
      wait_tx(44, "ovf_b3");
      wait_tx(44, "ovf_b4");
      no_tx(60, "ovf_extra");
      chk("ovf_sticky", fifo_ovf, 1'b1);

      // Push into a full FIFO in the same cycle it is popped
      do_reset();
      @(negedge clk);
      req0_vld = 1'b1;
      req0_data = 8'h90;
      exp_q.push_back(8'h90);
      wait_tx(1, "fp_host");
      req0_vld = 1'b0;
      rx_push(8'h11, 1'b1);
      rx_push(8'h12, 1'b1);
      rx_push(8'h13, 1'b1);
      rx_push(8'h14, 1'b1);
      quiet(38);
      rx_push(8'h15, 1'b1);
      #1;
      chk("fp_idle", busy, 1'b0);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
      wait_tx(1, "fp_b1");
      chk("fp_no_ovf", fifo_ovf, 1'b0);
      wait_tx(44, "fp_b2");
      wait_tx(44, "fp_b3");
      wait_tx(44, "fp_b4");
      wait_tx(44, "fp_b5");
      no_tx(60, "fp_extra");

      // Reset in the middle of HOLD (timer = 20)
      @(negedge clk);
      req0_vld = 1'b1;
      req0_data = 8'hA5;
      exp_q.push_back(8'hA5);
      wait_tx(1, "mr_host");
      req0_vld = 1'b0;
      rx_push(8'hC1, 1'b1);
      rx_push(8'hC2, 1'b1);
      rx_push(8'hC3, 1'b1);
      rx_push(8'hC4, 1'b1);
      rx_push(8'hC5, 1'b1);
      quiet(16);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mr_pre_ovf", fifo_ovf, 1'b1);
      chk("mr_pre_busy", busy, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      req0_vld = 1'b1;
      req0_data = 8'hE7;
      #1;
      chk("mr_busy", busy, 1'b0);
      chk("mr_tx_vld", tx_vld, 1'b0);
      chk("mr_ovf", fifo_ovf, 1'b0);
      chk("mr_tx_data", tx_data, 8'h00);
      chk("mr_rdy", req0_rdy, 1'b1);
      exp_q.push_back(8'hE7);
      wait_tx(1, "mr_new");
      req0_vld = 1'b0;
      no_tx(60, "mr_fifo_empty");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, 10416, clk cycles per UART bit.
REQ-002 SHALL have parameter FRAME_BITS, 10, bits per frame (start + 8 data + stop).
REQ-003 SHALL have parameter GAP_CYCLES, 2, idle guard cycles after each frame.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low (rst=0 resets on the next clk edge).
REQ-006 SHALL have port req0_vld  input  1  host byte valid.
REQ-007 SHALL have port req0_data  input  8  host byte.
REQ-008 SHALL have port req0_rdy  output  1  host byte accepted this cycle.
REQ-009 SHALL have port rx_vld  input  1  one-cycle pulse from UART receiver, no backpressure.
REQ-010 SHALL have port rx_data  input  8  received byte.
REQ-011 SHALL have port echo_en  input  1  enable echo of received bytes.
REQ-012 SHALL have port tx_vld  output  1  one-cycle start pulse to UART sender dout_vld.
REQ-013 SHALL have port tx_data  output  8  byte to UART sender dout_data, stable from the tx_vld cycle until the next tx_vld.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port fifo_ovf  output  1  sticky echo-FIFO overflow flag.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, HOLD.
REQ-017 SHALL define FRAME_CYCLES = CLK_DIV*FRAME_BITS + GAP_CYCLES; timer width SHALL be clog2(FRAME_CYCLES+1) (17 bits at default).
REQ-018 SHALL buffer echo bytes in a 4-entry FIFO; rx_vld=1 with echo_en=1 pushes rx_data; rx_vld with echo_en=0 SHALL be discarded.
REQ-019 SHALL, in IDLE, treat source 0 as pending when req0_vld=1 and source 1 as pending when FIFO is non-empty.
REQ-020 SHALL arbitrate round-robin: when both are pending, grant the source not granted last; when one is pending, grant it.
REQ-021 SHALL assert req0_rdy combinationally only in IDLE when source 0 is granted; the handshake completes when req0_vld and req0_rdy are both high.
REQ-022 SHALL, on grant, register the granted byte into tx_data, pop the FIFO if source 1 was granted, update last_grant, and move to LOAD.
REQ-023 SHALL assert tx_vld=1 for exactly the one LOAD cycle, then load the timer with FRAME_CYCLES-1 and move to HOLD.
REQ-024 SHALL decrement the timer in HOLD and move to IDLE on the cycle the timer equals 0; consecutive tx_vld pulses are therefore exactly FRAME_CYCLES+2 cycles apart.
REQ-025 SHALL make grant-to-tx_vld latency exactly 1 cycle.
REQ-026 SHALL, on push while the FIFO is full and no pop occurs that cycle, drop the byte and set fifo_ovf=1 until reset.
REQ-027 SHALL accept a push while full when a pop occurs in the same cycle; occupancy stays 4 and fifo_ovf stays unchanged.
REQ-028 SHALL accept FIFO pushes in every state, including LOAD and HOLD.
REQ-029 SHALL wrap FIFO read and write pointers modulo 4 without loss of ordering.

Reset
REQ-030 SHALL, on rst=0, set state=IDLE, timer=0, tx_vld=0, tx_data=8'h00, busy=0, fifo_ovf=0, FIFO empty, and last_grant=1 so that source 0 wins the first tie.
REQ-031 SHALL abort any frame in progress when reset occurs mid-LOAD or mid-HOLD; the UART sender SHALL share the same reset.
REQ-032 SHALL drive req0_rdy=0 while rst=0.

Structure
REQ-033 SHALL place the state enum (IDLE/LOAD/HOLD) and default CLK_DIV, FRAME_BITS and GAP_CYCLES constants in a shared package uart_pkg.
REQ-034 SHALL instantiate one sub-module, sync_fifo (8-bit wide, depth 4, push/pop/full/empty outputs).

Verification (CLK_DIV=4, FRAME_BITS=10, GAP_CYCLES=2, so FRAME_CYCLES=42)
REQ-035 SHALL verify a single host byte: req0_vld=1 with 8'h41 in IDLE -> req0_rdy=1 that cycle, tx_vld=1 next cycle with tx_data=8'h41, busy=1 for 43 cycles, then IDLE.
REQ-036 SHALL verify a tie: req0 holding 8'h55 and FIFO holding 8'hA0 after reset -> tx_data sequence 8'h55, 8'hA0, with tx_vld pulses 44 cycles apart.
REQ-037 SHALL verify echo gating: rx_vld pulses with 8'h31 (echo_en=0) and 8'h32 (echo_en=1) -> only 8'h32 is transmitted.
REQ-038 SHALL verify overflow: six rx_vld pulses 8'h01..8'h06 within HOLD (echo_en=1) -> fifo_ovf=1; transmitted bytes are 8'h01..8'h04 only.
REQ-039 SHALL verify reset mid-HOLD: rst=0 for 1 cycle at timer=20 -> next cycle busy=0, tx_vld=0, FIFO empty, fifo_ovf=0, and a new req0 byte is granted immediately.
